// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes and
// datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MADDR  = 4'd3,
        S_MRD    = 4'd4,
        S_MWB    = 4'd5,
        S_MWR    = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_JMP    = 4'd10,
        S_AWB    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUSRCB_B      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that wait on the memory handshake and are guarded by the watchdog.
    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MRD) || (s == S_MWR);
    endfunction

endpackage

// File: rtl/mips_mem_watchdog.sv
// Counts consecutive not-ready cycles in a memory state and flags expiry when the
// limit is reached and memory is still not ready.
module mips_mem_watchdog #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic ready_i,
    output logic expire_o
);
    localparam int W = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] LIMIT = W'(MAX_WAIT);

    logic [W-1:0] wait_cnt_q, wait_cnt_d;

    assign expire_o = active_i && !ready_i && (wait_cnt_q == LIMIT);

    // Expiry always forces a state change, so the count never needs to pass LIMIT.
    always_comb begin
        wait_cnt_d = '0;
        if (active_i && !ready_i && (wait_cnt_q != LIMIT))
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt_q <= '0;
        else        wait_cnt_q <= wait_cnt_d;
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB over a shared ALU and a
// single memory, stalling on mem_ready and aborting hung accesses to IDLE.
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);
    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q;
    logic       expire;

    mips_mem_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .active_i (is_mem_state(state_q)),
        .ready_i  (mem_ready),
        .expire_o (expire)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)   state_d = S_DECODE;
                else if (expire) state_d = S_IDLE;
            end
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_RTYPE:             state_d = S_EXEC;
                    OP_LW, OP_SW, OP_ADDI: state_d = S_MADDR;
                    OP_BEQ:               state_d = S_BEQ;
                    OP_J:                 state_d = S_JMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MADDR: begin
                case (op_q)
                    OP_LW:   state_d = S_MRD;
                    OP_SW:   state_d = S_MWR;
                    OP_ADDI: state_d = S_AWB;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MRD: begin
                if (mem_ready)   state_d = S_MWB;
                else if (expire) state_d = S_IDLE;
            end
            S_MWR: begin
                if (mem_ready)   state_d = S_FETCH;
                else if (expire) state_d = S_IDLE;
            end
            S_EXEC:  state_d = S_RWB;
            S_MWB, S_RWB, S_AWB, S_BEQ, S_JMP: state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            timeout_q <= expire;
        end
    end

    // Moore decode from the state register so reset drops every strobe at once;
    // only FETCH looks at mem_ready, to load IR/PC on the completing cycle.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUSRCB_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                alu_src_b = ALUSRCB_FOUR;
            end
            S_DECODE: alu_src_b = ALUSRCB_IMM_SH;
            S_MADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_IMM;
            end
            S_MRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_AWB: reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for the multi-cycle controller: an instruction-path model checked every
// cycle, plus directed sequences with hand-written expected state traces.
module tb_mips_multicycle_controller;
    localparam int MAXW = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op, mem_timeout;
    logic [3:0] state;

    mips_multicycle_controller #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
        .state(state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [15:0] dut_ctrl;
    assign dut_ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    // Expected control word for a given state, straight from the per-state output list.
    function automatic logic [15:0] exp_ctrl(int s, logic rdy);
        logic pw, pwc, io, mr, mw, irw, rdst, m2r, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, io, mr, mw, irw, rdst, m2r, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s)
            1:  begin mr = 1; irw = rdy; pw = rdy; asb = 2'b01; end
            2:  asb = 2'b11;
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mr = 1; io = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mw = 1; io = 1; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rw = 1; rdst = 1; end
            9:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            10: begin pw = 1; psrc = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, irw, rdst, m2r, rw, asa, asb, aop, psrc};
    endfunction

    // Model: each instruction is a list of states to walk after DECODE; memory
    // states only move on when ready, or abort to IDLE after MAXW stalled cycles.
    int ms = 0;
    int wc = 0;
    int path[$];
    logic m_ill = 0, m_to = 0;

    function automatic int next_on_path();
        if (path.size() == 0) return 1;
        return path.pop_front();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms = 0; wc = 0; m_ill = 0; m_to = 0;
            path.delete();
        end else begin
            m_ill = 0;
            m_to  = 0;
            if (ms == 0) begin
                ms = 1;
            end else if (ms == 1 || ms == 4 || ms == 6) begin
                if (mem_ready) begin
                    wc = 0;
                    ms = (ms == 1) ? 2 : next_on_path();
                end else if (wc == MAXW) begin
                    wc = 0; ms = 0; m_to = 1;
                    path.delete();
                end else begin
                    wc++;
                end
            end else if (ms == 2) begin
                path.delete();
                case (opcode)
                    6'b000000: path = '{7, 8};
                    6'b100011: path = '{3, 4, 5};
                    6'b101011: path = '{3, 6};
                    6'b001000: path = '{3, 11};
                    6'b000100: path = '{9};
                    6'b000010: path = '{10};
                    default:   m_ill = 1;
                endcase
                ms = next_on_path();
            end else begin
                ms = next_on_path();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_state", {28'd0, state}, ms);
            chk("model_ctrl", {16'd0, dut_ctrl}, {16'd0, exp_ctrl(ms, mem_ready)});
            chk("model_illegal", {31'd0, illegal_op}, {31'd0, m_ill});
            chk("model_timeout", {31'd0, mem_timeout}, {31'd0, m_to});
        end
    end

    typedef struct packed {
        logic [3:0] st;
        logic       pwc;
        logic [1:0] aop;
        logic [1:0] psrc;
        logic       rd;
        logic       io;
        logic       rw;
        logic       rdst;
        logic       wr;
        logic       ill;
        logic       to;
    } snap_t;
    snap_t lg[$];

    task automatic step(logic [5:0] op, logic rdy);
        snap_t s;
        opcode    = op;
        mem_ready = rdy;
        @(posedge clk);
        #1;
        s.st = state; s.pwc = pc_write_cond; s.aop = alu_op; s.psrc = pc_source;
        s.rd = mem_read; s.io = iord; s.rw = reg_write; s.rdst = reg_dst;
        s.wr = mem_write; s.ill = illegal_op; s.to = mem_timeout;
        lg.push_back(s);
    endtask

    task automatic chk_seq(string name, input int e[$]);
        chk({name, "_len"}, lg.size(), e.size());
        for (int i = 0; i < e.size() && i < lg.size(); i++)
            chk($sformatf("%s[%0d]", name, i), {28'd0, lg[i].st}, e[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int e[$];
        int n;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("reset_state", {28'd0, state}, 0);
        chk("reset_ctrl", {16'd0, dut_ctrl}, 0);
        chk("reset_pulses", {30'd0, illegal_op, mem_timeout}, 0);
        rst_n = 1'b1;

        // R-type, no stalls
        lg.delete();
        repeat (5) step(6'b000000, 1'b1);
        e = '{1, 2, 7, 8, 1};
        chk_seq("rtype_seq", e);
        for (int i = 0; i < lg.size(); i++)
            chk("rtype_rw_rd", {30'd0, lg[i].rw, lg[i].rdst}, (lg[i].st == 4'd8) ? 3 : 0);

        // lw with three not-ready cycles in MRD (third leaves the counter at its limit)
        lg.delete();
        repeat (3) step(6'b100011, 1'b1);
        repeat (3) step(6'b100011, 1'b0);
        repeat (2) step(6'b100011, 1'b1);
        e = '{2, 3, 4, 4, 4, 4, 5, 1};
        chk_seq("lw_seq", e);
        n = 0;
        for (int i = 0; i < lg.size(); i++)
            if (lg[i].st == 4'd4) begin
                n++;
                chk("lw_mrd_rd_iord", {30'd0, lg[i].rd, lg[i].io}, 3);
            end
        chk("lw_mrd_cycles", n, 4);
        n = 0;
        foreach (lg[i]) if (lg[i].st == 4'd5) n++;
        chk("lw_mwb_cycles", n, 1);

        // beq
        lg.delete();
        repeat (3) step(6'b000100, 1'b1);
        e = '{2, 9, 1};
        chk_seq("beq_seq", e);
        n = 0;
        foreach (lg[i]) if (lg[i].pwc) n++;
        chk("beq_pwc_cycles", n, 1);
        chk("beq_aop_psrc", {28'd0, lg[1].pwc, lg[1].aop, lg[1].psrc}, 5'b1_01_01);

        // illegal opcode, then a jump
        lg.delete();
        repeat (2) step(6'b111111, 1'b1);
        repeat (3) step(6'b000010, 1'b1);
        e = '{2, 1, 2, 10, 1};
        chk_seq("ill_j_seq", e);
        n = 0;
        foreach (lg[i]) if (lg[i].ill) n++;
        chk("illegal_pulses", n, 1);
        chk("illegal_in_fetch", {31'd0, lg[1].ill}, 1);
        n = 0;
        foreach (lg[i]) if (lg[i].rw || lg[i].wr) n++;
        chk("illegal_no_writes", n, 0);

        // addi after two stalled fetch cycles
        lg.delete();
        repeat (2) step(6'b001000, 1'b0);
        repeat (4) step(6'b001000, 1'b1);
        e = '{1, 1, 2, 3, 11, 1};
        chk_seq("addi_seq", e);
        chk("addi_awb_rw_rd", {30'd0, lg[4].rw, lg[4].rdst}, 2);

        // sw that never completes: watchdog abort
        lg.delete();
        repeat (3) step(6'b101011, 1'b1);
        repeat (4) step(6'b101011, 1'b0);
        step(6'b101011, 1'b1);
        e = '{2, 3, 6, 6, 6, 6, 0, 1};
        chk_seq("sw_to_seq", e);
        n = 0;
        foreach (lg[i]) if (lg[i].to) n++;
        chk("timeout_pulses", n, 1);
        chk("timeout_in_idle", {31'd0, lg[6].to}, 1);

        // asynchronous reset in the middle of MWR
        lg.delete();
        repeat (3) step(6'b101011, 1'b1);
        chk("pre_reset_mwr", {28'd0, state}, 6);
        mem_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_state", {28'd0, state}, 0);
        chk("midrst_ctrl", {16'd0, dut_ctrl}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_release_idle", {28'd0, state}, 0);
        step(6'b000000, 1'b1);
        chk("fetch_after_release", {28'd0, state}, 1);
        step(6'b000000, 1'b1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
